// File: rtl/sat_add_pipe.sv
// Pipelined signed adder with saturate/wrap overflow handling, an
// accumulate mode for tap summation and a valid/ready stream interface.
// Stage 1 does the arithmetic; later stages only delay the result.
module sat_add_pipe #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 2,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    acc_mode,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] c,
  output logic                    ovf
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("sat_add_pipe: STAGES must be in 1..4");
    end
  endgenerate

  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow shows up as the extra sign bit disagreeing with the truncated
  // sign bit, which is the same as "operands agree in sign, result doesn't".
  function automatic logic add_ovf(input logic signed [WIDTH:0] sum);
    return sum[WIDTH] ^ sum[WIDTH-1];
  endfunction

  // On overflow the wide sum's MSB is the operands' common sign, so it
  // picks the clamp direction.
  function automatic logic signed [WIDTH-1:0] clamp_res(input logic signed [WIDTH:0] sum,
                                                        input logic o);
    logic signed [WIDTH-1:0] r;
    r = sum[WIDTH-1:0];
    if (o && SATURATE != 0) r = sum[WIDTH] ? MIN_V : MAX_V;
    return r;
  endfunction

  logic                    advance;
  logic                    accept;
  logic signed [WIDTH-1:0] y_p0;
  logic signed [WIDTH:0]   sum_p0;
  logic                    ovf_p0;
  logic signed [WIDTH-1:0] res_p0;

  logic [STAGES-1:0]       vld_q, vld_d;
  logic [STAGES-1:0]       ovf_q, ovf_d;
  logic signed [WIDTH-1:0] data_q [STAGES];
  logic signed [WIDTH-1:0] data_d [STAGES];
  logic signed [WIDTH-1:0] acc_q, acc_d;

  // Handshake, stage-1 arithmetic and next state of pipeline and accumulator.
  always_comb begin
    advance  = !vld_q[STAGES-1] || out_ready;
    in_ready = advance && !rst;
    accept   = in_valid && in_ready;

    // ---- stage 1 input: operand select and add ----
    if (!acc_mode)    y_p0 = b;
    else if (acc_clr) y_p0 = '0;
    else              y_p0 = acc_q;
    sum_p0 = {a[WIDTH-1], a} + {y_p0[WIDTH-1], y_p0};
    ovf_p0 = add_ovf(sum_p0);
    res_p0 = clamp_res(sum_p0, ovf_p0);

    vld_d  = vld_q;
    ovf_d  = ovf_q;
    data_d = data_q;
    acc_d  = acc_q;

    // ---- stage boundaries: shift everything together, or hold everything ----
    if (advance) begin
      vld_d[0]  = accept;
      ovf_d[0]  = ovf_p0;
      data_d[0] = res_p0;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        ovf_d[i]  = ovf_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end

    // Updating at accept lets back-to-back accumulate beats chain at any depth.
    if (accept && acc_mode) acc_d = res_p0;
  end

  // State registers; reset discards in-flight beats and clears the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      acc_q  <= acc_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign c         = data_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_sat_add_pipe.sv
// Randomized and directed bench for sat_add_pipe. Two instances share all
// inputs: one saturating, one wrapping. A queue-based integer model predicts
// every result in order.
module tb_sat_add_pipe;

  localparam int W      = 16;
  localparam int STG    = 2;
  localparam int MAXV   = (1 << (W-1)) - 1;
  localparam int MINV   = -(1 << (W-1));
  localparam int MODV   = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, in_valid, out_ready, acc_mode, acc_clr;
  logic signed [W-1:0] a, b;
  logic                in_ready, out_valid, ovf;
  logic signed [W-1:0] c;
  logic                in_ready_w, out_valid_w, ovf_w;
  logic signed [W-1:0] c_w;

  sat_add_pipe #(.WIDTH(W), .STAGES(STG), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf));

  sat_add_pipe #(.WIDTH(W), .STAGES(STG), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid_w), .out_ready(out_ready), .c(c_w), .ovf(ovf_w));

  typedef struct {
    int c_s; bit o_s; int c_w; bit o_w; int cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   acc_s = 0, acc_w = 0;
  int   cyc = 0, last_stall = -1;
  bit   took;
  bit   hold_pend = 0;
  int   hold_c = 0;
  bit   hold_o = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: exact sum, then clamp or wrap into range.
  function automatic void model_add(input int x, input int y, input bit sat,
                                    output int r, output bit o);
    int s;
    s = x + y;
    o = (s > MAXV) || (s < MINV);
    if (!o)       r = s;
    else if (sat) r = (s > MAXV) ? MAXV : MINV;
    else          r = (s > MAXV) ? s - MODV : s + MODV;
  endfunction

  // Evaluate one cycle shortly after the falling edge, then wait for the next one.
  task automatic tick();
    exp_t e;
    int   ys, yw;
    #1;
    cyc++;
    took = 0;
    if (rst) begin
      q.delete();
      acc_s = 0;
      acc_w = 0;
      hold_pend = 0;
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      chk("inst_sync", int'({in_ready_w, out_valid_w}), int'({in_ready, out_valid}));
      if (hold_pend) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_c", int'(c), hold_c);
        chk("hold_ovf", int'(ovf), int'(hold_o));
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else if (out_ready) begin
          e = q.pop_front();
          chk("c_sat", int'(c), e.c_s);
          chk("ovf_sat", int'(ovf), int'(e.o_s));
          chk("c_wrap", int'(c_w), e.c_w);
          chk("ovf_wrap", int'(ovf_w), int'(e.o_w));
          if (e.cyc > last_stall) chk("latency", cyc - e.cyc, STG);
        end
      end
      if (in_valid && in_ready) begin
        took = 1;
        ys = acc_mode ? (acc_clr ? 0 : acc_s) : int'(b);
        yw = acc_mode ? (acc_clr ? 0 : acc_w) : int'(b);
        model_add(int'(a), ys, 1'b1, e.c_s, e.o_s);
        model_add(int'(a), yw, 1'b0, e.c_w, e.o_w);
        e.cyc = cyc;
        if (acc_mode) begin
          acc_s = e.c_s;
          acc_w = e.c_w;
        end
        q.push_back(e);
      end
      if (!out_ready) last_stall = cyc;
      hold_pend = out_valid && !out_ready;
      hold_c    = int'(c);
      hold_o    = ovf;
    end
    @(negedge clk);
  endtask

  task automatic send(input int av, input int bv, input bit m, input bit clr);
    a = W'(av); b = W'(bv); acc_mode = m; acc_clr = clr;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (took) break;
    end
    if (!took) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 5))
      0:       return MAXV;
      1:       return MINV;
      2:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($signed(W'($urandom)));
    endcase
  endfunction

  initial begin
    int nacc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; acc_mode = 1'b0; acc_clr = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(in_ready), 1);

    // Basic, signed and overflow beats back to back
    send(10, 12, 0, 0);
    send(69, 96, 0, 0);
    send(1990, 1921, 0, 0);
    send(-5, 5, 0, 0);
    send(-3731, 8, 0, 0);
    send(-32768, 32767, 0, 0);
    send(30000, 10000, 0, 0);
    send(-30000, -10000, 0, 0);
    send(-32768, -32768, 0, 0);
    send(32767, 1, 0, 0);
    drain();

    // Accumulate chain with saturation and an interleaved plain add
    send(1000, 0, 1, 1);
    send(2000, 0, 1, 0);
    send(3000, 0, 1, 0);
    send(30000, 0, 1, 0);
    send(4, 4, 0, 1);
    send(0, 0, 1, 0);
    drain();

    // Backpressure: only STG beats fit while the output is blocked
    out_ready = 1'b0;
    nacc = 0;
    a = 16'sd101; b = 16'sd1; acc_mode = 1'b0; acc_clr = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (took) begin
        nacc++;
        a = W'(101 + nacc);
      end
    end
    chk("bp_accepts", nacc, STG);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (nacc < 5) begin
      send(101 + nacc, 1, 0, 0);
      nacc++;
    end
    drain();

    // Reset with beats in flight, then a fresh accumulate beat
    send(500, 0, 1, 0);
    send(600, 0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_c", int'(c), 0);
    send(7, 0, 1, 0);
    drain();

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = W'(rnd_val());
      b         = W'(rnd_val());
      acc_mode  = $urandom_range(0, 1) == 1;
      acc_clr   = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
